// File: rtl/param_sample_buffer.sv
// param_sample_buffer: first-word fall-through sample buffer with drop accounting.
// The upstream generator has no backpressure, so a sample arriving while the
// buffer is full (and nothing leaves that cycle) is discarded. Each discard
// sets a sticky overflow flag and bumps a saturating 8-bit drop counter.
module param_sample_buffer #(
   parameter int WIDTH = 8,   // sample width in bits (1..64)
   parameter int DEPTH = 8    // entries, power of two, >= 2
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic [WIDTH-1:0]           in_data,
   input  logic                       in_valid,
   input  logic                       clear,
   output logic [WIDTH-1:0]           out_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output logic                       empty,
   output logic                       overflow,
   output logic [7:0]                 drop_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count_q;
   logic             overflow_q;
   logic [7:0]       drop_q;

   logic             pop_en;
   logic             push_en;
   logic             drop_en;

   // Status is decoded from the registered count only, so nothing on the
   // output side ever depends combinationally on in_valid.
   assign empty     = (count_q == '0);
   assign full      = (count_q == CW'(DEPTH));
   assign out_valid = !empty;
   assign out_data  = mem[rd_ptr];
   assign count     = count_q;
   assign overflow  = overflow_q;
   assign drop_count = drop_q;

   // A pop frees a slot in the same cycle, so a full buffer can still accept
   // a sample when downstream is reading.
   assign pop_en  = out_valid && out_ready;
   assign push_en = in_valid && (!full || pop_en);
   assign drop_en = in_valid && full && !pop_en;

   // Control state: pointers, occupancy and overflow accounting.
   // NOTE: sequential state uses non-blocking (<=) so every register samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         drop_q     <= '0;
      end else if (clear) begin
         // Flush wins over any push, pop or drop in the same cycle.
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         drop_q     <= '0;
      end else begin
         // Pointers are exactly log2(DEPTH) bits, so they wrap naturally.
         if (push_en) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop_en) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push_en, pop_en})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
         if (drop_en) begin
            overflow_q <= 1'b1;
            if (drop_q != 8'hFF) begin
               drop_q <= drop_q + 8'd1;
            end
         end
      end
   end

   // Sample storage write port.
   // NOTE: the storage array has no reset; validity is tracked entirely by the
   // pointers and count, which keeps the array mappable to plain RAM.
   always_ff @(posedge clk) begin
      if (push_en && !clear && reset_n) begin
         mem[wr_ptr] <= in_data;
      end
   end

endmodule

// File: tb/tb_param_sample_buffer.sv
// Directed bench for param_sample_buffer: an 8-bit, depth-4 instance for the
// main function and boundary cases, plus a 16-bit, depth-4 instance fed by a
// simple bench-side sample generator and drained continuously.
module tb_param_sample_buffer;

   logic        clk = 1'b0;
   logic        reset_n;

   // 8-bit, depth-4 instance
   logic [7:0]  in_data;
   logic        in_valid;
   logic        clear;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_ready;
   logic [2:0]  count;
   logic        full;
   logic        empty;
   logic        overflow;
   logic [7:0]  drop_count;

   // 16-bit, depth-4 instance driven by the generator
   logic [15:0] param_data_out;
   logic        param_valid;
   logic        clear16;
   logic [15:0] out_data16;
   logic        out_valid16;
   logic        out_ready16;
   logic [2:0]  count16;
   logic        full16;
   logic        empty16;
   logic        overflow16;
   logic [7:0]  drop_count16;

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0]  mq[$];
   logic [15:0] gq[$];

   always #5 clk = ~clk;

   param_sample_buffer #(.WIDTH(8), .DEPTH(4)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .clear      (clear),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .count      (count),
      .full       (full),
      .empty      (empty),
      .overflow   (overflow),
      .drop_count (drop_count)
   );

   param_sample_buffer #(.WIDTH(16), .DEPTH(4)) dut16 (
      .clk        (clk),
      .reset_n    (reset_n),
      .in_data    (param_data_out),
      .in_valid   (param_valid),
      .clear      (clear16),
      .out_data   (out_data16),
      .out_valid  (out_valid16),
      .out_ready  (out_ready16),
      .count      (count16),
      .full       (full16),
      .empty      (empty16),
      .overflow   (overflow16),
      .drop_count (drop_count16)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and settle just after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // ---------------- reset, inputs active during reset ----------------
      reset_n        = 1'b0;
      in_data        = 8'hAA;
      in_valid       = 1'b1;
      clear          = 1'b0;
      out_ready      = 1'b1;
      param_data_out = 16'hDEAD;
      param_valid    = 1'b1;
      clear16        = 1'b0;
      out_ready16    = 1'b1;
      #1;
      check("rst_count",     count, 0);
      check("rst_empty",     empty, 1);
      check("rst_full",      full, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_overflow",  overflow, 0);
      check("rst_drop",      drop_count, 0);
      for (int i = 0; i < 3; i++) step();
      check("rst_ignore_in", count, 0);
      check("rst16_ignore",  count16, 0);
      in_valid    = 1'b0;
      out_ready   = 1'b0;
      param_valid = 1'b0;
      reset_n     = 1'b1;
      step();
      check("post_rst_empty", empty, 1);

      // ---------------- single push, one-cycle latency, no bypass ----------------
      in_data  = 8'h11;
      in_valid = 1'b1;
      #1;
      check("no_bypass", out_valid, 0);
      step();
      in_valid = 1'b0;
      check("lat_out_valid", out_valid, 1);
      check("lat_out_data",  out_data, 8'h11);
      check("lat_count",     count, 1);
      check("lat_empty",     empty, 0);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("pop1_empty", empty, 1);
      check("pop1_count", count, 0);

      // ---------------- fill to full ----------------
      for (int i = 1; i <= 4; i++) begin
         in_data  = 8'(i);
         in_valid = 1'b1;
         step();
      end
      check("fill_full",  full, 1);
      check("fill_count", count, 4);

      // ---------------- drops while full ----------------
      in_data = 8'h55;
      step();
      in_data = 8'h66;
      step();
      in_valid = 1'b0;
      check("drop_overflow", overflow, 1);
      check("drop_count2",   drop_count, 2);
      check("drop_keep_cnt", count, 4);
      check("drop_head",     out_data, 8'h01);
      in_data  = 8'h77;
      in_valid = 1'b1;
      for (int i = 0; i < 300; i++) step();
      in_valid = 1'b0;
      check("drop_sat",      drop_count, 255);
      check("drop_sticky",   overflow, 1);

      // ---------------- drain in order ----------------
      out_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         check("drain_valid", out_valid, 1);
         check("drain_data",  out_data, 64'(i));
         step();
      end
      out_ready = 1'b0;
      check("drain_empty", empty, 1);
      check("drain_ovf_sticky", overflow, 1);

      // ---------------- clear overrides push/pop ----------------
      for (int i = 0; i < 3; i++) begin
         in_data  = 8'hC0 + 8'(i);
         in_valid = 1'b1;
         step();
      end
      check("pre_clear_count", count, 3);
      in_data   = 8'hCF;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      clear     = 1'b1;
      step();
      clear     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      check("clear_count",    count, 0);
      check("clear_empty",    empty, 1);
      check("clear_overflow", overflow, 0);
      check("clear_drop",     drop_count, 0);

      // ---------------- simultaneous push/pop while full, pointer wrap ----------------
      mq.delete();
      for (int i = 0; i < 4; i++) begin
         in_data  = 8'hB0 + 8'(i);
         in_valid = 1'b1;
         mq.push_back(8'hB0 + 8'(i));
         step();
      end
      check("pp_full", full, 1);
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         in_data = 8'hA0 + 8'(i);
         check("pp_data", out_data, mq[0]);
         step();
         void'(mq.pop_front());
         mq.push_back(8'hA0 + 8'(i));
         check("pp_count", count, 4);
         check("pp_nodrop", drop_count, 0);
      end
      check("pp_no_overflow", overflow, 0);
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check("pp_drain", out_data, mq[0]);
         void'(mq.pop_front());
         step();
      end
      out_ready = 1'b0;
      check("pp_end_empty", empty, 1);

      // ---------------- reset mid-operation ----------------
      in_valid = 1'b1;
      in_data  = 8'h21;
      step();
      in_data  = 8'h22;
      step();
      in_valid = 1'b0;
      check("mid_pre_count", count, 2);
      #3;
      reset_n = 1'b0;
      #1;
      check("mid_async_count", count, 0);
      check("mid_async_empty", empty, 1);
      check("mid_async_valid", out_valid, 0);
      step();
      reset_n = 1'b1;
      step();
      in_data  = 8'h77;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      check("mid_after_data",  out_data, 8'h77);
      check("mid_after_count", count, 1);

      // ---------------- 16-bit instance fed by the generator ----------------
      gq.delete();
      out_ready16 = 1'b1;
      for (int k = 0; k < 40; k++) begin
         param_valid    = ((k % 3) != 2);
         param_data_out = 16'h1234 + 16'(k) * 16'h0101;
         #1;
         if (out_valid16) begin
            if (gq.size() == 0) begin
               check("gen_spurious", out_valid16, 0);
            end else begin
               check("gen_data", out_data16, gq[0]);
               void'(gq.pop_front());
            end
         end
         if (param_valid) gq.push_back(param_data_out);
         step();
      end
      param_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         #1;
         if (out_valid16 && gq.size() != 0) begin
            check("gen_tail", out_data16, gq[0]);
            void'(gq.pop_front());
         end
         step();
      end
      check("gen_all_out", 64'(gq.size()), 0);
      check("gen_empty",   empty16, 1);
      check("gen_no_drop", drop_count16, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/param_sample_buffer.md
PARAM_SAMPLE_BUFFER -- requirements
Module: param_sample_buffer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, sample width in bits (1..64).
REQ-002 The block SHALL have parameter DEPTH, default 8, buffer entries (power of two, >= 2).
REQ-003 Ports SHALL be:
- clk  input  1  single clock; all logic on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_data  input  WIDTH  sample from upstream generator.
- in_valid  input  1  in_data valid this cycle; no backpressure to upstream.
- clear  input  1  synchronous flush.
- out_data  output  WIDTH  head-of-buffer sample.
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accepts out_data.
- count  output  $clog2(DEPTH+1)  entries held.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- overflow  output  1  sticky; a sample was dropped.
- drop_count  output  8  dropped samples, saturating.

Function
REQ-004 Push SHALL occur on a rising edge when in_valid=1 and (full=0 or pop occurs in the same cycle).
REQ-005 Pop SHALL occur on a rising edge when out_valid=1 and out_ready=1.
REQ-006 Buffer SHALL be first-word fall-through: out_data = oldest stored entry, out_valid = !empty, both derived from registered state only.
REQ-007 Latency SHALL be one cycle: a sample pushed at edge N is visible on out_data/out_valid after edge N when the buffer was empty.
REQ-008 No combinational bypass: in_valid with empty=1 SHALL NOT assert out_valid in the same cycle.
REQ-009 Simultaneous push and pop SHALL leave count unchanged and SHALL be legal when full=1 (no drop).
REQ-010 count SHALL be +1 on push-only, -1 on pop-only, unchanged otherwise; full/empty SHALL be decoded from count.
REQ-011 Read and write pointers SHALL be $clog2(DEPTH) bits and wrap from DEPTH-1 to 0 without gap.
REQ-012 Drop SHALL occur when in_valid=1, full=1 and no pop: sample discarded, buffer contents unchanged, overflow set to 1, drop_count incremented.
REQ-013 drop_count SHALL saturate at 255; overflow SHALL remain 1 until clear or reset.
REQ-014 clear=1 SHALL, at the next edge, set count=0, both pointers=0, overflow=0, drop_count=0, overriding any push, pop or drop in that cycle.
REQ-015 out_data when empty=1 SHALL be don't-care for checking; out_valid=0 SHALL be the only validity indicator.
REQ-016 Storage array SHALL NOT be reset; only control state and counters are reset.

Reset
REQ-017 While reset_n=0 (asynchronously on assertion): count=0, pointers=0, empty=1, full=0, out_valid=0, overflow=0, drop_count=0.
REQ-018 Reset asserted mid-operation SHALL discard all stored samples; first push after release behaves per REQ-007.
REQ-019 in_valid/out_ready during reset SHALL be ignored.

Verification (WIDTH=8, DEPTH=4 unless stated)
REQ-020 Reset then push 0x11 one cycle, out_ready=0 -> after that edge out_valid=1, out_data=0x11, count=1, empty=0.
REQ-021 Push 0x01..0x04 with out_ready=0 -> full=1, count=4; then out_ready=1, in_valid=0 -> out_data sequence 0x01,0x02,0x03,0x04, then empty=1.
REQ-022 Full buffer, push 0x55 and 0x66 with out_ready=0 -> both dropped, overflow=1, drop_count=2, contents unchanged; 300 further drops -> drop_count=255.
REQ-023 Full buffer, in_valid=1 and out_ready=1 for 6 cycles, data 0xA0..0xA5 -> count stays 4, no drop, outputs in order through pointer wrap.
REQ-024 count=3, overflow=1, assert clear with in_valid=1 and out_ready=1 -> next edge count=0, empty=1, overflow=0, drop_count=0.
REQ-025 WIDTH=16, DEPTH=4 connected to the 16-bit generator outputs (param_data_out -> in_data, param_valid -> in_valid); drain with out_ready=1 -> out_data sequence equals generator output sequence with no loss.
